// File: rtl/descramble_ctrl_pkg.sv
// Shared RX constants and the descrambler sequencer state type.
// Also imported by the signal/header decoder.
package descramble_ctrl_pkg;

    localparam int SEED_BITS    = 7;
    localparam int SERVICE_BITS = 16;
    localparam int DISCARD_BITS = SERVICE_BITS - SEED_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_SEED,
        ST_SERVICE,
        ST_DATA,
        ST_DRAIN
    } rx_state_t;

endpackage

// File: rtl/descramble_ctrl_lsb_byte_packer.sv
// Collects descrambled bits LSB-first and emits a one-cycle strobe
// on the cycle after the eighth bit lands.
module lsb_byte_packer (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       byte_complete,
    output logic [7:0] byte_out,
    output logic       byte_strobe
);

    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    assign byte_complete = bit_valid && (bit_cnt == 3'd7);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            byte_out    <= '0;
            byte_strobe <= 1'b0;
        end else begin
            byte_strobe <= byte_complete;
            if (bit_valid) begin
                shreg   <= {bit_in, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7)
                    byte_out <= {bit_in, shreg[7:1]};
            end
        end
    end

endmodule

// File: rtl/descramble_ctrl.sv
// Per-PPDU sequencer wrapped around the bit-serial descrambler: resets it,
// feeds it the seed, drops SERVICE bits and packs PSDU bits into bytes.
module descramble_ctrl
    import descramble_ctrl_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             pkt_start,
    input  logic [LEN_W-1:0] psdu_len,
    input  logic             in_bit,
    input  logic             input_strobe,
    output logic             desc_reset,
    output logic             desc_enable,
    output logic             desc_in_bit,
    output logic             desc_input_strobe,
    input  logic             desc_out_bit,
    input  logic             desc_output_strobe,
    output logic [7:0]       byte_out,
    output logic             byte_out_strobe,
    output logic [LEN_W-1:0] byte_count,
    output logic             pkt_done,
    output logic             busy
);

    rx_state_t        state;
    logic [LEN_W-1:0] len_q;
    logic [4:0]       phase_cnt;
    logic             active;
    logic             data_valid;
    logic             byte_complete;

    assign active            = (state == ST_SEED) || (state == ST_SERVICE) || (state == ST_DATA);
    assign desc_reset        = reset || (state == ST_RST);
    assign desc_enable       = active && enable;
    assign desc_in_bit       = active && in_bit;
    assign desc_input_strobe = active && enable && input_strobe;
    assign busy              = (state != ST_IDLE) && (state != ST_DRAIN);

    // Once the last byte has been counted, stray bits still in flight are ignored.
    assign data_valid = (state == ST_DATA) && enable && desc_output_strobe
                        && (byte_count != len_q);

    lsb_byte_packer u_packer (
        .clock         (clock),
        .reset         (reset),
        .clear         (pkt_start),
        .bit_valid     (data_valid),
        .bit_in        (desc_out_bit),
        .byte_complete (byte_complete),
        .byte_out      (byte_out),
        .byte_strobe   (byte_out_strobe)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            phase_cnt  <= '0;
            byte_count <= '0;
            pkt_done   <= 1'b0;
        end else if (pkt_start) begin
            state      <= ST_RST;
            len_q      <= psdu_len;
            phase_cnt  <= '0;
            byte_count <= '0;
            pkt_done   <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (enable) begin
                case (state)
                    ST_RST: begin
                        state     <= ST_SEED;
                        phase_cnt <= '0;
                    end
                    ST_SEED: begin
                        if (input_strobe) begin
                            if (phase_cnt == 5'(SEED_BITS - 1)) begin
                                state     <= ST_SERVICE;
                                phase_cnt <= '0;
                            end else begin
                                phase_cnt <= phase_cnt + 5'd1;
                            end
                        end
                    end
                    // The seed never produces output, so these are the remaining SERVICE bits.
                    ST_SERVICE: begin
                        if (desc_output_strobe) begin
                            if (phase_cnt == 5'(DISCARD_BITS - 1)) begin
                                phase_cnt <= '0;
                                if (len_q == '0) begin
                                    pkt_done <= 1'b1;
                                    state    <= ST_DRAIN;
                                end else begin
                                    state <= ST_DATA;
                                end
                            end else begin
                                phase_cnt <= phase_cnt + 5'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (byte_complete && (byte_count != '1))
                            byte_count <= byte_count + 1'b1;
                        if (byte_count == len_q) begin
                            pkt_done <= 1'b1;
                            state    <= ST_DRAIN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_descramble_ctrl.sv
// Drives scrambled PPDUs through descramble_ctrl and a behavioural 802.11
// descrambler, checking bytes, strobes and framing against the original PSDU.
module tb_descramble_ctrl;

    localparam int LEN_W = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b1;
    logic             pkt_start = 1'b0;
    logic [LEN_W-1:0] psdu_len = '0;
    logic             in_bit = 1'b0;
    logic             input_strobe = 1'b0;
    logic             desc_reset, desc_enable, desc_in_bit, desc_input_strobe;
    logic             desc_out_bit, desc_output_strobe;
    logic [7:0]       byte_out;
    logic             byte_out_strobe, pkt_done, busy;
    logic [LEN_W-1:0] byte_count;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    descramble_ctrl #(.LEN_W(LEN_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .pkt_start          (pkt_start),
        .psdu_len           (psdu_len),
        .in_bit             (in_bit),
        .input_strobe       (input_strobe),
        .desc_reset         (desc_reset),
        .desc_enable        (desc_enable),
        .desc_in_bit        (desc_in_bit),
        .desc_input_strobe  (desc_input_strobe),
        .desc_out_bit       (desc_out_bit),
        .desc_output_strobe (desc_output_strobe),
        .byte_out           (byte_out),
        .byte_out_strobe    (byte_out_strobe),
        .byte_count         (byte_count),
        .pkt_done           (pkt_done),
        .busy               (busy)
    );

    // Behavioural descrambler: first 7 bits load the state, later bits are
    // descrambled with x^7+x^4+1 and presented one cycle after the input.
    logic [6:0] dsc_state;
    int         dsc_cnt;
    always @(posedge clock) begin
        if (desc_reset) begin
            dsc_state          <= '0;
            dsc_cnt            <= 0;
            desc_out_bit       <= 1'b0;
            desc_output_strobe <= 1'b0;
        end else begin
            desc_output_strobe <= 1'b0;
            if (desc_enable && desc_input_strobe) begin
                if (dsc_cnt < 7) begin
                    dsc_state <= {dsc_state[5:0], desc_in_bit};
                    dsc_cnt   <= dsc_cnt + 1;
                end else begin
                    desc_out_bit       <= desc_in_bit ^ dsc_state[6] ^ dsc_state[3];
                    dsc_state          <= {dsc_state[5:0], dsc_state[6] ^ dsc_state[3]};
                    desc_output_strobe <= 1'b1;
                end
            end
        end
    end

    logic [7:0] got_q[$];
    int cyc = 0;
    int done_cnt, rst_cycles, bad_strobes, last_byte_cyc, done_cyc, last_ostb_cyc;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (byte_out_strobe) begin
                got_q.push_back(byte_out);
                last_byte_cyc = cyc;
            end
            if (pkt_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (desc_reset) rst_cycles = rst_cycles + 1;
            if (desc_output_strobe) last_ostb_cyc = cyc;
            if (!enable && (byte_out_strobe || desc_input_strobe || pkt_done || desc_enable))
                bad_strobes = bad_strobes + 1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    logic [7:0] psdu_q[$];
    logic       tx_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        done_cnt = 0; rst_cycles = 0; bad_strobes = 0;
        last_byte_cyc = 0; done_cyc = 0; last_ostb_cyc = 0;
    endtask

    // Transmit-side additive scrambler applied to SERVICE + PSDU + extra bits.
    task automatic build_stream(input logic [6:0] seed, input int n_extra);
        logic [6:0] s;
        logic       x, d;
        int         n_data, k;
        tx_q.delete();
        s = seed;
        n_data = 8 * psdu_q.size();
        for (int i = 0; i < 16 + n_data + n_extra; i++) begin
            if (i < 16) d = 1'b0;
            else if (i < 16 + n_data) begin
                k = i - 16;
                d = psdu_q[k / 8][k % 8];
            end else d = 1'($urandom_range(0, 1));
            x = s[6] ^ s[3];
            s = {s[5:0], x};
            tx_q.push_back(d ^ x);
        end
    endtask

    task automatic start_pkt(input int len);
        psdu_len  = LEN_W'(len);
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        tick();
    endtask

    task automatic send_range(input int from, input int upto, input int gmin, input int gmax);
        for (int i = from; i <= upto; i++) begin
            in_bit       = tx_q[i];
            input_strobe = 1'b1;
            tick();
            input_strobe = 1'b0;
            repeat ($urandom_range(gmin, gmax)) tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_cmp += 6;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        if (byte_count !== '0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", byte_count); end
        if (byte_out_strobe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobe: got %0b expected 0", byte_out_strobe); end
        if (pkt_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %0b expected 0", pkt_done); end
        if (byte_out !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_byte: got %0h expected 0", byte_out); end
        if (desc_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_desc_reset: got %0b expected 1", desc_reset); end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (desc_reset !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_desc_reset: got %0b expected 0", desc_reset); end
    endtask

    task automatic test_basic();
        clear_mon();
        psdu_q = '{8'h01, 8'h80, 8'hA5};
        build_stream(7'h5D, 0);
        start_pkt(3);
        send_range(0, tx_q.size() - 1, 0, 0);
        repeat (6) tick();
        n_cmp += 5;
        if (got_q.size() !== 3) begin n_fail++; $display("[TB] FAIL basic_nbytes: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== psdu_q[i]) begin n_fail++; $display("[TB] FAIL basic_byte%0d: got %0h expected %0h", i, got_q[i], psdu_q[i]); end
        end
        if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL basic_done: got %0d expected 1", done_cnt); end
        if (done_cyc - last_byte_cyc !== 1) begin n_fail++; $display("[TB] FAIL basic_done_lat: got %0d expected 1", done_cyc - last_byte_cyc); end
        if (byte_count !== 16'd3) begin n_fail++; $display("[TB] FAIL basic_count: got %0d expected 3", byte_count); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_zero_len();
        clear_mon();
        psdu_q.delete();
        build_stream(7'($urandom_range(1, 127)), 0);
        start_pkt(0);
        send_range(0, 15, 0, 0);
        repeat (6) tick();
        n_cmp += 5;
        if (got_q.size() !== 0) begin n_fail++; $display("[TB] FAIL zero_nbytes: got %0d expected 0", got_q.size()); end
        if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL zero_done: got %0d expected 1", done_cnt); end
        if (done_cyc !== last_ostb_cyc + 1) begin n_fail++; $display("[TB] FAIL zero_done_cyc: got %0d expected %0d", done_cyc, last_ostb_cyc + 1); end
        if (byte_count !== '0) begin n_fail++; $display("[TB] FAIL zero_count: got %0d expected 0", byte_count); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_gaps_enable();
        clear_mon();
        psdu_q = '{8'h01, 8'h80, 8'hA5};
        build_stream(7'h5D, 0);
        start_pkt(3);
        send_range(0, 27, 4, 4);
        enable = 1'b0;
        in_bit = 1'b1;
        input_strobe = 1'b1;
        repeat (3) tick();
        input_strobe = 1'b0;
        repeat (7) tick();
        enable = 1'b1;
        send_range(28, tx_q.size() - 1, 4, 4);
        repeat (6) tick();
        n_cmp += 3;
        if (got_q.size() !== 3) begin n_fail++; $display("[TB] FAIL gaps_nbytes: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== psdu_q[i]) begin n_fail++; $display("[TB] FAIL gaps_byte%0d: got %0h expected %0h", i, got_q[i], psdu_q[i]); end
        end
        if (bad_strobes !== 0) begin n_fail++; $display("[TB] FAIL gaps_disabled_strobes: got %0d expected 0", bad_strobes); end
        if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL gaps_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_abort();
        logic [7:0] exp_q[$];
        clear_mon();
        psdu_q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        exp_q.push_back(psdu_q[0]);
        build_stream(7'($urandom_range(1, 127)), 0);
        start_pkt(4);
        send_range(0, 16 + 11, 0, 1);
        psdu_q = '{8'($urandom), 8'($urandom)};
        exp_q.push_back(psdu_q[0]);
        exp_q.push_back(psdu_q[1]);
        build_stream(7'($urandom_range(1, 127)), 0);
        start_pkt(2);
        send_range(0, tx_q.size() - 1, 0, 1);
        repeat (6) tick();
        n_cmp += 3;
        if (rst_cycles !== 2) begin n_fail++; $display("[TB] FAIL abort_rst_cycles: got %0d expected 2", rst_cycles); end
        if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL abort_done: got %0d expected 1", done_cnt); end
        if (got_q.size() !== 3) begin n_fail++; $display("[TB] FAIL abort_nbytes: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL abort_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_tail_drain();
        clear_mon();
        psdu_q = '{8'($urandom), 8'($urandom)};
        build_stream(7'($urandom_range(1, 127)), 26);
        start_pkt(2);
        send_range(0, tx_q.size() - 1, 0, 2);
        repeat (4) tick();
        n_cmp += 4;
        if (got_q.size() !== 2) begin n_fail++; $display("[TB] FAIL tail_nbytes: got %0d expected 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== psdu_q[i]) begin n_fail++; $display("[TB] FAIL tail_byte%0d: got %0h expected %0h", i, got_q[i], psdu_q[i]); end
        end
        if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL tail_done: got %0d expected 1", done_cnt); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL tail_busy: got %0b expected 0", busy); end
        if (byte_count !== 16'd2) begin n_fail++; $display("[TB] FAIL tail_count: got %0d expected 2", byte_count); end
    endtask

    task automatic test_reset_in_data();
        clear_mon();
        psdu_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        build_stream(7'($urandom_range(1, 127)), 0);
        start_pkt(3);
        send_range(0, 16 + 9, 0, 0);
        reset = 1'b1;
        pkt_start = 1'b1;
        psdu_len = 16'd5;
        tick();
        pkt_start = 1'b0;
        n_cmp += 7;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_data_busy: got %0b expected 0", busy); end
        if (byte_count !== '0) begin n_fail++; $display("[TB] FAIL rst_data_count: got %0d expected 0", byte_count); end
        if (byte_out !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_data_byte: got %0h expected 0", byte_out); end
        if (byte_out_strobe !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_data_strobe: got %0b expected 0", byte_out_strobe); end
        if (pkt_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_data_done: got %0b expected 0", pkt_done); end
        if (desc_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_data_desc_en: got %0b expected 0", desc_enable); end
        if (desc_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_data_desc_reset: got %0b expected 1", desc_reset); end
        reset = 1'b0;
        repeat (3) tick();
        n_cmp += 2;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_prio_busy: got %0b expected 0", busy); end
        if (done_cnt !== 0) begin n_fail++; $display("[TB] FAIL rst_data_nodone: got %0d expected 0", done_cnt); end
    endtask

    task automatic test_random();
        int len;
        for (int p = 0; p < 5; p++) begin
            clear_mon();
            len = $urandom_range(1, 6);
            psdu_q.delete();
            for (int b = 0; b < len; b++) psdu_q.push_back(8'($urandom));
            build_stream(7'($urandom_range(1, 127)), $urandom_range(0, 30));
            start_pkt(len);
            send_range(0, tx_q.size() - 1, 0, $urandom_range(0, 3));
            repeat (5) tick();
            n_cmp += 3;
            if (got_q.size() !== len) begin n_fail++; $display("[TB] FAIL rand%0d_nbytes: got %0d expected %0d", p, got_q.size(), len); end
            for (int i = 0; i < len && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== psdu_q[i]) begin n_fail++; $display("[TB] FAIL rand%0d_byte%0d: got %0h expected %0h", p, i, got_q[i], psdu_q[i]); end
            end
            if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL rand%0d_done: got %0d expected 1", p, done_cnt); end
            if (byte_count !== LEN_W'(len)) begin n_fail++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", p, byte_count, len); end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_zero_len();
        test_gaps_enable();
        test_abort();
        test_tail_drain();
        test_reset_in_data();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
